fifo_status_monitor: RTL and testbench

- Producer side of the FIFO status interface consumed by the transaction control FSM.
- Latches the three programmed thresholds (umbralMF, umbralVC, umbralD) when init is asserted.
- Tracks the occupancy of the five transaction FIFOs from their push/pop strobes.
- Drives Fifo_empties and Fifo_errors back to the control FSM, plus almost-full/almost-empty flags and a pause request for the upstream flow control.

---
 rtl/fifo_status_monitor_pkg.sv | 32 +++
 rtl/fifo_status_monitor_if.sv | 25 ++
 rtl/fifo_status_monitor_occupancy_counter.sv | 71 +++++++
 rtl/fifo_status_monitor.sv | 142 ++++++++++++++
 tb/tb_fifo_status_monitor.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_status_monitor_pkg.sv
// Shared definitions for the FIFO status monitor: state encoding, FIFO
// index map and the saturating error-event accumulator.
package fifo_status_monitor_pkg;

  localparam int unsigned NUM_FIFOS   = 5;
  localparam int unsigned MF          = 0;
  localparam int unsigned VC0         = 1;
  localparam int unsigned VC1         = 2;
  localparam int unsigned D0          = 3;
  localparam int unsigned D1          = 4;
  localparam int unsigned ERR_TOTAL_W = 8;

  typedef enum logic [1:0] {
    UNCFG = 2'd0,
    CFG   = 2'd1,
    ERR   = 2'd2
  } state_e;

  // Adds one per asserted event bit, saturating at the all-ones value.
  function automatic logic [ERR_TOTAL_W-1:0] sat_add_errs(
    input logic [ERR_TOTAL_W-1:0] acc,
    input logic [NUM_FIFOS-1:0]   ev
  );
    logic [ERR_TOTAL_W:0] sum;
    sum = {1'b0, acc};
    for (int unsigned i = 0; i < NUM_FIFOS; i++) begin
      sum = sum + {{ERR_TOTAL_W{1'b0}}, ev[i]};
    end
    return sum[ERR_TOTAL_W] ? '1 : sum[ERR_TOTAL_W-1:0];
  endfunction

endpackage

// File: rtl/fifo_status_monitor_if.sv
// Status bus between the FIFO strobes / control FSM (master) and the
// status monitor (slave).
interface fifo_status_monitor_if;
  import fifo_status_monitor_pkg::*;

  logic [NUM_FIFOS-1:0] push;
  logic [NUM_FIFOS-1:0] pop;
  logic [NUM_FIFOS-1:0] Fifo_empties;
  logic [NUM_FIFOS-1:0] Fifo_errors;
  logic [NUM_FIFOS-1:0] almost_full;
  logic [NUM_FIFOS-1:0] almost_empty;
  logic                 pause;
  logic                 configured;

  modport master (
    output push, pop,
    input  Fifo_empties, Fifo_errors, almost_full, almost_empty, pause, configured
  );

  modport slave (
    input  push, pop,
    output Fifo_empties, Fifo_errors, almost_full, almost_empty, pause, configured
  );

endinterface

// File: rtl/fifo_status_monitor_occupancy_counter.sv
// Occupancy counter for one FIFO: tracks count from push/pop strobes,
// reports a per-cycle overflow/underflow event and derives the
// empty / almost flags from the registered count only.
module fifo_occupancy_counter #(
  parameter int unsigned LENGTH = 4,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned CNT_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic              flag_en,
  input  logic [LENGTH-1:0] threshold,
  output logic [CNT_W-1:0]  count,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              err_event
);

  // Comparison width wide enough for both the count and the threshold.
  localparam int unsigned CMP_W = ((LENGTH > CNT_W) ? LENGTH : CNT_W) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CMP_W-1:0] DEPTH_X = CMP_W'(DEPTH);

  logic [CNT_W-1:0] count_q, count_d;
  logic [CMP_W-1:0] thr_x, cnt_x, full_lim;

  // Next count and error event from the strobes.
  always_comb begin
    count_d   = count_q;
    err_event = 1'b0;
    unique case ({push, pop})
      2'b10: begin
        if (count_q == DEPTH_C) err_event = 1'b1;
        else                    count_d   = count_q + 1'b1;
      end
      2'b01: begin
        if (count_q == '0) err_event = 1'b1;
        else               count_d   = count_q - 1'b1;
      end
      2'b11: begin
        // Empty FIFO: the push lands, the pop still underflows.
        if (count_q == '0) begin
          count_d   = CNT_W'(1);
          err_event = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Occupancy register.
  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  // Status flags from the registered count; a zero threshold disables them.
  always_comb begin
    thr_x        = CMP_W'(threshold);
    cnt_x        = CMP_W'(count_q);
    full_lim     = (DEPTH_X > thr_x) ? (DEPTH_X - thr_x) : '0;
    count        = count_q;
    empty        = (count_q == '0);
    almost_full  = flag_en && (thr_x != '0) && (cnt_x >= full_lim);
    almost_empty = flag_en && (thr_x != '0) && (cnt_x <= thr_x);
  end

endmodule

// File: rtl/fifo_status_monitor.sv
// FIFO status monitor top: threshold registers, sticky error bits,
// configuration FSM and pause generation over five occupancy counters.
// Optional saturating error-event counter: define FIFO_STATUS_ERR_COUNT_EN.
module fifo_status_monitor
  import fifo_status_monitor_pkg::*;
#(
  parameter int unsigned LENGTH = 4,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned CNT_W  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     init,
  input  logic [LENGTH-1:0]        umbralMF,
  input  logic [LENGTH-1:0]        umbralVC,
  input  logic [LENGTH-1:0]        umbralD,
  input  logic                     err_clr,
`ifdef FIFO_STATUS_ERR_COUNT_EN
  output logic [ERR_TOTAL_W-1:0]   err_total,
`endif
  fifo_status_monitor_if.slave     sif
);

  state_e state_q, state_d;
  logic [LENGTH-1:0]    thr_mf_q, thr_mf_d;
  logic [LENGTH-1:0]    thr_vc_q, thr_vc_d;
  logic [LENGTH-1:0]    thr_d_q,  thr_d_d;
  logic [NUM_FIFOS-1:0] err_q, err_d;
  logic                 latch_thr;
  logic                 flag_en;

  logic [LENGTH-1:0]    fifo_thr [NUM_FIFOS];
  logic [CNT_W-1:0]     cnt_w    [NUM_FIFOS];
  logic [NUM_FIFOS-1:0] empty_w, af_w, ae_w, ev_w;

  // Route each FIFO to the threshold of its class.
  always_comb begin
    for (int unsigned i = 0; i < NUM_FIFOS; i++) begin
      if (i == MF)       fifo_thr[i] = thr_mf_q;
      else if (i <= VC1) fifo_thr[i] = thr_vc_q;
      else               fifo_thr[i] = thr_d_q;
    end
  end

  assign flag_en = (state_q == CFG) || (state_q == ERR);

  for (genvar g = 0; g < NUM_FIFOS; g++) begin : g_fifo
    fifo_occupancy_counter #(
      .LENGTH (LENGTH),
      .DEPTH  (DEPTH),
      .CNT_W  (CNT_W)
    ) u_cnt (
      .clk          (clk),
      .reset        (reset),
      .push         (sif.push[g]),
      .pop          (sif.pop[g]),
      .flag_en      (flag_en),
      .threshold    (fifo_thr[g]),
      .count        (cnt_w[g]),
      .empty        (empty_w[g]),
      .almost_full  (af_w[g]),
      .almost_empty (ae_w[g]),
      .err_event    (ev_w[g])
    );

    // Occupancy must never exceed the FIFO depth.
    always_ff @(posedge clk) begin
      if (!reset) assert (cnt_w[g] <= CNT_W'(DEPTH));
    end
  end

  // FSM next state, threshold latch and sticky errors; a new event beats err_clr.
  always_comb begin
    state_d   = state_q;
    latch_thr = 1'b0;
    err_d     = (err_clr ? '0 : err_q) | ev_w;
    unique case (state_q)
      UNCFG: begin
        if (init) begin
          latch_thr = 1'b1;
          state_d   = CFG;
        end
      end
      CFG: begin
        if (init)   latch_thr = 1'b1;
        if (|ev_w)  state_d   = ERR;
      end
      ERR: begin
        if (err_clr && !(|ev_w)) state_d = CFG;
      end
      default: state_d = UNCFG;
    endcase
    thr_mf_d = latch_thr ? umbralMF : thr_mf_q;
    thr_vc_d = latch_thr ? umbralVC : thr_vc_q;
    thr_d_d  = latch_thr ? umbralD  : thr_d_q;
  end

  // State, threshold and error registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= UNCFG;
      thr_mf_q <= '0;
      thr_vc_q <= '0;
      thr_d_q  <= '0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      thr_mf_q <= thr_mf_d;
      thr_vc_q <= thr_vc_d;
      thr_d_q  <= thr_d_d;
      err_q    <= err_d;
    end
  end

  // Status outputs; pause is suppressed outside CFG.
  always_comb begin
    sif.Fifo_empties = empty_w;
    sif.Fifo_errors  = err_q;
    sif.almost_full  = af_w;
    sif.almost_empty = ae_w;
    sif.pause        = (state_q == CFG) && (|af_w);
    sif.configured   = flag_en;
  end

`ifdef FIFO_STATUS_ERR_COUNT_EN
  logic [ERR_TOTAL_W-1:0] err_total_q, err_total_d;

  // Saturating total of error events; only reset clears it.
  always_comb begin
    err_total_d = sat_add_errs(err_total_q, ev_w);
  end

  // Error total register.
  always_ff @(posedge clk) begin
    if (reset) err_total_q <= '0;
    else       err_total_q <= err_total_d;
  end

  assign err_total = err_total_q;
`endif

endmodule

// File: tb/tb_fifo_status_monitor.sv
// Self-checking bench for fifo_status_monitor: directed vector table,
// hand-written corner sequences and randomized traffic against a model.
module tb_fifo_status_monitor;
  import fifo_status_monitor_pkg::*;

  localparam int LENGTH = 4;
  localparam int DEPTH  = 8;
  localparam int CNT_W  = 4;

  logic clk = 1'b0;
  logic reset, init, err_clr;
  logic [LENGTH-1:0] umbralMF, umbralVC, umbralD;
`ifdef FIFO_STATUS_ERR_COUNT_EN
  logic [7:0] err_total;
`endif

  fifo_status_monitor_if sif();

  fifo_status_monitor #(
    .LENGTH (LENGTH),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .init      (init),
    .umbralMF  (umbralMF),
    .umbralVC  (umbralVC),
    .umbralD   (umbralD),
    .err_clr   (err_clr),
`ifdef FIFO_STATUS_ERR_COUNT_EN
    .err_total (err_total),
`endif
    .sif       (sif.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // ---------------- behavioural model ----------------
  int   m_cnt [5];
  int   m_thr [5];
  bit   m_configured;
  bit   m_in_err;
  logic [4:0] m_err;
  int   m_total;

  task automatic model_step();
    logic [4:0] ev;
    int n;
    ev = '0;
    if (reset) begin
      for (int i = 0; i < 5; i++) begin m_cnt[i] = 0; m_thr[i] = 0; end
      m_configured = 0; m_in_err = 0; m_err = '0; m_total = 0;
      return;
    end
    for (int i = 0; i < 5; i++) begin
      bit p, q;
      p = sif.push[i]; q = sif.pop[i];
      if (p && !q) begin
        if (m_cnt[i] < DEPTH) m_cnt[i]++; else ev[i] = 1'b1;
      end else if (q && !p) begin
        if (m_cnt[i] > 0) m_cnt[i]--; else ev[i] = 1'b1;
      end else if (p && q && m_cnt[i] == 0) begin
        m_cnt[i] = 1; ev[i] = 1'b1;
      end
    end
    n = 0;
    for (int i = 0; i < 5; i++) n += ev[i];
    m_total = (m_total + n > 255) ? 255 : m_total + n;
    if (!m_configured) begin
      if (init) begin
        m_thr[0] = umbralMF; m_thr[1] = umbralVC; m_thr[2] = umbralVC;
        m_thr[3] = umbralD;  m_thr[4] = umbralD;
        m_configured = 1;
      end
    end else if (!m_in_err) begin
      if (init) begin
        m_thr[0] = umbralMF; m_thr[1] = umbralVC; m_thr[2] = umbralVC;
        m_thr[3] = umbralD;  m_thr[4] = umbralD;
      end
      if (ev != 0) m_in_err = 1;
    end else if (err_clr && ev == 0) begin
      m_in_err = 0;
    end
    m_err = (err_clr ? 5'b0 : m_err) | ev;
  endtask

  function automatic logic [4:0] m_af();
    logic [4:0] r;
    int lim;
    for (int i = 0; i < 5; i++) begin
      lim  = (DEPTH > m_thr[i]) ? DEPTH - m_thr[i] : 0;
      r[i] = m_configured && m_thr[i] != 0 && m_cnt[i] >= lim;
    end
    return r;
  endfunction

  function automatic logic [4:0] m_ae();
    logic [4:0] r;
    for (int i = 0; i < 5; i++) r[i] = m_configured && m_thr[i] != 0 && m_cnt[i] <= m_thr[i];
    return r;
  endfunction

  function automatic logic [4:0] m_emp();
    logic [4:0] r;
    for (int i = 0; i < 5; i++) r[i] = (m_cnt[i] == 0);
    return r;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    cyc++;
    #1;
  endtask

  task automatic check_vs_model(input string tag);
    logic [4:0] af;
    af = m_af();
    chk({tag, ".empties"},    {3'b0, sif.Fifo_empties}, {3'b0, m_emp()});
    chk({tag, ".errors"},     {3'b0, sif.Fifo_errors},  {3'b0, m_err});
    chk({tag, ".almost_full"},{3'b0, sif.almost_full},  {3'b0, af});
    chk({tag, ".almost_empty"},{3'b0, sif.almost_empty},{3'b0, m_ae()});
    chk({tag, ".pause"},      {7'b0, sif.pause},        {7'b0, (m_configured && !m_in_err && af != 0)});
    chk({tag, ".configured"}, {7'b0, sif.configured},   {7'b0, m_configured});
`ifdef FIFO_STATUS_ERR_COUNT_EN
    chk({tag, ".err_total"},  err_total, 8'(m_total));
`endif
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [4:0] push, pop;
    logic       init, clr, rst;
    logic [4:0] e_emp, e_err, e_af, e_ae;
    logic       e_pause, e_cfg;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic [4:0] pu, input logic [4:0] po, input logic in,
                              input logic cl, input logic rs, input logic [4:0] emp,
                              input logic [4:0] er, input logic [4:0] af, input logic [4:0] ae,
                              input logic pa, input logic cf);
    vec_t v;
    v.push = pu; v.pop = po; v.init = in; v.clr = cl; v.rst = rs;
    v.e_emp = emp; v.e_err = er; v.e_af = af; v.e_ae = ae; v.e_pause = pa; v.e_cfg = cf;
    vecs.push_back(v);
  endfunction

  initial begin
    reset = 1'b1; init = 1'b0; err_clr = 1'b0;
    umbralMF = 4'd2; umbralVC = 4'd3; umbralD = 4'd1;
    sif.push = '0; sif.pop = '0;

    //    push      pop       in cl rs  empties   errors    a_full    a_empty pause cfg
    add(5'b00000, 5'b00000, 0, 0, 1, 5'b11111, 5'b00000, 5'b00000, 5'b00000, 0, 0);
    add(5'b00000, 5'b00000, 1, 0, 0, 5'b11111, 5'b00000, 5'b00000, 5'b11111, 0, 1);
    add(5'b00001, 5'b00000, 0, 0, 0, 5'b11110, 5'b00000, 5'b00000, 5'b11111, 0, 1);
    add(5'b00001, 5'b00000, 0, 0, 0, 5'b11110, 5'b00000, 5'b00000, 5'b11111, 0, 1);
    for (int k = 3; k <= 5; k++)
      add(5'b00001, 5'b00000, 0, 0, 0, 5'b11110, 5'b00000, 5'b00000, 5'b11110, 0, 1);
    add(5'b00001, 5'b00000, 0, 0, 0, 5'b11110, 5'b00000, 5'b00001, 5'b11110, 1, 1);
    add(5'b01000, 5'b00000, 0, 0, 0, 5'b10110, 5'b00000, 5'b00001, 5'b11110, 1, 1);
    for (int j = 2; j <= 6; j++)
      add(5'b01000, 5'b00000, 0, 0, 0, 5'b10110, 5'b00000, 5'b00001, 5'b10110, 1, 1);
    add(5'b01000, 5'b00000, 0, 0, 0, 5'b10110, 5'b00000, 5'b01001, 5'b10110, 1, 1);
    add(5'b01000, 5'b00000, 0, 0, 0, 5'b10110, 5'b00000, 5'b01001, 5'b10110, 1, 1);
    add(5'b01000, 5'b00000, 0, 0, 0, 5'b10110, 5'b01000, 5'b01001, 5'b10110, 0, 1);
    add(5'b00000, 5'b00010, 0, 1, 0, 5'b10110, 5'b00010, 5'b01001, 5'b10110, 0, 1);
    add(5'b00000, 5'b00000, 0, 1, 0, 5'b10110, 5'b00000, 5'b01001, 5'b10110, 1, 1);
    for (int m = 1; m <= 3; m++)
      add(5'b00100, 5'b00000, 0, 0, 0, 5'b10010, 5'b00000, 5'b01001, 5'b10110, 1, 1);
    add(5'b00100, 5'b00000, 0, 0, 0, 5'b10010, 5'b00000, 5'b01001, 5'b10010, 1, 1);
    for (int m = 5; m <= 8; m++)
      add(5'b00100, 5'b00000, 0, 0, 0, 5'b10010, 5'b00000, 5'b01101, 5'b10010, 1, 1);
    add(5'b00100, 5'b00100, 0, 0, 0, 5'b10010, 5'b00000, 5'b01101, 5'b10010, 1, 1);
    add(5'b00010, 5'b00010, 0, 0, 0, 5'b10000, 5'b00010, 5'b01101, 5'b10010, 0, 1);
    add(5'b00000, 5'b00000, 0, 0, 1, 5'b11111, 5'b00000, 5'b00000, 5'b00000, 0, 0);

    foreach (vecs[n]) begin
      sif.push = vecs[n].push; sif.pop = vecs[n].pop;
      init = vecs[n].init; err_clr = vecs[n].clr; reset = vecs[n].rst;
      tick();
      chk($sformatf("vec%0d.empties", n),      {3'b0, sif.Fifo_empties}, {3'b0, vecs[n].e_emp});
      chk($sformatf("vec%0d.errors", n),       {3'b0, sif.Fifo_errors},  {3'b0, vecs[n].e_err});
      chk($sformatf("vec%0d.almost_full", n),  {3'b0, sif.almost_full},  {3'b0, vecs[n].e_af});
      chk($sformatf("vec%0d.almost_empty", n), {3'b0, sif.almost_empty}, {3'b0, vecs[n].e_ae});
      chk($sformatf("vec%0d.pause", n),        {7'b0, sif.pause},        {7'b0, vecs[n].e_pause});
      chk($sformatf("vec%0d.configured", n),   {7'b0, sif.configured},   {7'b0, vecs[n].e_cfg});
    end
`ifdef FIFO_STATUS_ERR_COUNT_EN
    chk("reset.err_total", err_total, 8'd0);
`endif

    // Errors while unconfigured: sticky, state stays unconfigured, new error beats clear.
    sif.push = '0; sif.pop = 5'b11111; init = 0; err_clr = 0; reset = 0;
    tick();
    chk("uncfg.errors", {3'b0, sif.Fifo_errors}, 8'h1F);
    chk("uncfg.configured", {7'b0, sif.configured}, 8'h00);
    chk("uncfg.almost_empty", {3'b0, sif.almost_empty}, 8'h00);
`ifdef FIFO_STATUS_ERR_COUNT_EN
    chk("uncfg.err_total5", err_total, 8'd5);
`endif
    sif.pop = 5'b00001; err_clr = 1;
    tick();
    chk("uncfg.clr_vs_new", {3'b0, sif.Fifo_errors}, 8'h01);
    sif.pop = '0;
    tick();
    chk("uncfg.clr", {3'b0, sif.Fifo_errors}, 8'h00);
    err_clr = 0;
`ifdef FIFO_STATUS_ERR_COUNT_EN
    // 6 events so far; 50 more cycles of 5 underflows saturates at 255.
    sif.pop = 5'b11111;
    for (int k = 0; k < 50; k++) tick();
    chk("sat.err_total", err_total, 8'd255);
    sif.pop = '0; err_clr = 1;
    tick();
    chk("clr_keeps.err_total", err_total, 8'd255);
    err_clr = 0; reset = 1;
    tick();
    chk("reset2.err_total", err_total, 8'd0);
    reset = 0;
`endif

    // Randomized traffic against the model.
    reset = 1;
    tick();
    check_vs_model("rnd_reset");
    for (int k = 0; k < 3000; k++) begin
      logic [4:0] pu, po;
      for (int i = 0; i < 5; i++) begin
        pu[i] = ($urandom_range(0, 99) < 45);
        po[i] = ($urandom_range(0, 99) < 40);
      end
      sif.push = pu; sif.pop = po;
      reset    = ($urandom_range(0, 399) == 0);
      init     = ($urandom_range(0, 24) == 0) || (k == 0);
      err_clr  = ($urandom_range(0, 9) == 0);
      umbralMF = 4'($urandom_range(0, 15));
      umbralVC = 4'($urandom_range(0, 9));
      umbralD  = 4'($urandom_range(0, 9));
      tick();
      check_vs_model("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
